instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/imem_pkg.sv | 22 ++
 rtl/imem_byte_packer.sv | 53 +++++
 rtl/instr_mem_loader.sv | 151 +++++++++++++++
 tb/tb_instr_mem_loader.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: definitions shared by the instruction memory loader and its byte packer.
//   BYTE_W       - width of one load byte
//   PARITY_MAX_W - widest word even_parity() accepts (narrower words are zero-extended)
//   imem_state_e - loader FSM states
//   even_parity  - parity bit that makes the stored word plus the bit an even count of ones
package imem_pkg;

  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned PARITY_MAX_W = 256;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2
  } imem_state_e;

  // Zero-extension leaves the XOR reduction unchanged, so any word width up to the max works.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// imem_byte_packer: shifts bytes in MSB-first and assembles them into one DATA_W word.
//   clk, rst     - clock, asynchronous active-high reset (drops any partial word)
//   byte_valid   - byte_in is accepted this cycle
//   byte_in      - incoming byte
//   word         - assembled word, valid while word_ready is high
//   word_ready   - strobe: the last byte of a word is being accepted this cycle
//   byte_cnt     - bytes of the current word already accepted
module imem_byte_packer
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned Bytes = DATA_W / BYTE_W,
  localparam int unsigned CntW  = (Bytes > 1) ? $clog2(Bytes) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [DATA_W-1:0] word,
  output logic              word_ready,
  output logic [CntW-1:0]   byte_cnt
);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              last_byte;

  assign last_byte  = (cnt_q == CntW'(Bytes - 1));
  // The word is presented combinationally so the write lands on the last byte's own cycle.
  assign word       = (shift_q << BYTE_W) | DATA_W'(byte_in);
  assign word_ready = byte_valid && last_byte;
  assign byte_cnt   = cnt_q;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (byte_valid) begin
      shift_d = word;
      cnt_d   = last_byte ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: instruction memory filled by a byte-serial loader and read by a
// 1-cycle-latency fetch port. Fetches are only served while the loader is idle.
//   clk, rst                 - clock, asynchronous active-high reset (memory is not cleared)
//   ld_start/ld_base/ld_count - start a load of ld_count words at word address ld_base
//   ld_valid/ld_byte/ld_ready - byte stream, MSB-first within each word
//   busy, ld_done            - load in progress / one-cycle completion pulse
//   fetch_en/fetch_addr      - fetch request
//   instr, instr_valid       - registered fetch result
//   parity_err               - only with IMEM_PARITY_EN: fetched word failed its parity check
// Optional feature: define IMEM_PARITY_EN to store and check an even-parity bit per word.
module instr_mem_loader
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 6,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_count,
  input  logic              ld_valid,
  input  logic [BYTE_W-1:0] ld_byte,
  output logic              ld_ready,
  output logic              busy,
  output logic              ld_done,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid
`ifdef IMEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned CntW  = (DATA_W / BYTE_W > 1) ? $clog2(DATA_W / BYTE_W) : 1;

  logic [DATA_W-1:0] mem [Depth];

  imem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic              ld_ready_q, busy_q, ld_done_q;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;

  logic              byte_acc, word_ready, wr_en, fetch_acc;
  logic [DATA_W-1:0] wr_word;
  logic [CntW-1:0]   unused_byte_cnt;

  assign byte_acc = ld_valid && ld_ready_q;

  imem_byte_packer #(
    .DATA_W(DATA_W)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .byte_valid(byte_acc),
    .byte_in   (ld_byte),
    .word      (wr_word),
    .word_ready(word_ready),
    .byte_cnt  (unused_byte_cnt)
  );

  assign wr_en     = (state_q == StLoad) && word_ready;
  assign fetch_acc = (state_q == StIdle) && fetch_en;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    unique case (state_q)
      StIdle: begin
        if (ld_start) begin
          addr_d      = ld_base;
          remaining_d = ld_count;
          state_d     = (ld_count == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        if (word_ready) begin
          addr_d      = addr_q + 1'b1;  // natural wrap modulo Depth
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == (ADDR_W + 1)'(1)) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Read happens before any same-edge write, so a fetch sees pre-write contents.
    instr_d       = fetch_acc ? mem[fetch_addr] : instr_q;
    instr_valid_d = fetch_acc;
  end

  // FSM state and its registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      remaining_q   <= '0;
      ld_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      ld_done_q     <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      ld_ready_q    <= (state_d == StLoad);
      busy_q        <= (state_d != StIdle);
      ld_done_q     <= (state_d == StDone);
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Memory has no reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr_q] <= wr_word;
  end

`ifdef IMEM_PARITY_EN
  logic mem_par [Depth];
  logic parity_err_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_par[addr_q] <= even_parity(PARITY_MAX_W'(wr_word));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else if (fetch_acc) begin
      parity_err_q <= (even_parity(PARITY_MAX_W'(mem[fetch_addr])) != mem_par[fetch_addr]);
    end
  end

  assign parity_err = parity_err_q;
`endif

  assign ld_ready    = ld_ready_q;
  assign busy        = busy_q;
  assign ld_done     = ld_done_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

  localparam int DataW  = 32;
  localparam int AddrW  = 6;
  localparam int Depth  = 64;
  localparam int Bpw    = DataW / 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             ld_start;
  logic [AddrW-1:0] ld_base;
  logic [AddrW:0]   ld_count;
  logic             ld_valid;
  logic [7:0]       ld_byte;
  logic             ld_ready;
  logic             busy;
  logic             ld_done;
  logic             fetch_en;
  logic [AddrW-1:0] fetch_addr;
  logic [DataW-1:0] instr;
  logic             instr_valid;
`ifdef IMEM_PARITY_EN
  logic             parity_err;
`endif

  instr_mem_loader #(
    .DATA_W(DataW),
    .ADDR_W(AddrW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_start   (ld_start),
    .ld_base    (ld_base),
    .ld_count   (ld_count),
    .ld_valid   (ld_valid),
    .ld_byte    (ld_byte),
    .ld_ready   (ld_ready),
    .busy       (busy),
    .ld_done    (ld_done),
    .fetch_en   (fetch_en),
    .fetch_addr (fetch_addr),
    .instr      (instr),
    .instr_valid(instr_valid)
`ifdef IMEM_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: word-addressed memory, plus which words hold defined data.
  logic [DataW-1:0] model_mem [Depth];
  bit               model_known [Depth];
  logic [DataW-1:0] model_instr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_bytes(input int n, output logic [7:0] q [$]);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic do_fetch(input int addr);
    fetch_en   = 1'b1;
    fetch_addr = AddrW'(addr);
    tick();
    fetch_en    = 1'b0;
    model_instr = model_mem[addr];
    checks++;
    if (instr_valid !== 1'b1) $display("FAIL fetch_valid[%0d]: got %b want 1", addr, instr_valid);
    else passed++;
    checks++;
    if (instr !== model_instr) $display("FAIL fetch_data[%0d]: got %h want %h", addr, instr, model_instr);
    else passed++;
`ifdef IMEM_PARITY_EN
    checks++;
    if (parity_err !== 1'b0) $display("FAIL fetch_parity[%0d]: got %b want 0", addr, parity_err);
    else passed++;
`endif
    tick();
    checks++;
    if (instr_valid !== 1'b0 || instr !== model_instr)
      $display("FAIL fetch_hold[%0d]: got valid=%b instr=%h want 0/%h", addr, instr_valid, instr,
               model_instr);
    else passed++;
  endtask

  // Runs a full load; start_fetch >= 0 issues a fetch in the same cycle as ld_start.
  task automatic do_load(input int base, input int count, input logic [7:0] bytes [$],
                         input bit fetch_during, input int start_fetch);
    int pulses = 0;
    logic [DataW-1:0] w;
    ld_start = 1'b1;
    ld_base  = AddrW'(base);
    ld_count = (AddrW + 1)'(count);
    if (start_fetch >= 0) begin
      fetch_en   = 1'b1;
      fetch_addr = AddrW'(start_fetch);
    end
    tick();
    ld_start = 1'b0;
    fetch_en = 1'b0;
    if (start_fetch >= 0) begin
      checks++;
      if (instr_valid !== 1'b1 || instr !== model_mem[start_fetch])
        $display("FAIL start_fetch: got valid=%b instr=%h want 1/%h", instr_valid, instr,
                 model_mem[start_fetch]);
      else passed++;
      model_instr = model_mem[start_fetch];
    end
    checks++;
    if (busy !== 1'b1) $display("FAIL load_busy: got %b want 1", busy);
    else passed++;
    if (count == 0) begin
      checks++;
      if (ld_done !== 1'b1 || ld_ready !== 1'b0)
        $display("FAIL zero_done: got done=%b ready=%b want 1/0", ld_done, ld_ready);
      else passed++;
      tick();
      checks++;
      if (busy !== 1'b0 || ld_done !== 1'b0)
        $display("FAIL zero_idle: got busy=%b done=%b want 0/0", busy, ld_done);
      else passed++;
      return;
    end
    checks++;
    if (ld_ready !== 1'b1) $display("FAIL load_ready: got %b want 1", ld_ready);
    else passed++;
    for (int i = 0; i < bytes.size(); i++) begin
      repeat ($urandom_range(0, 2)) begin
        ld_valid   = 1'b0;
        fetch_en   = fetch_during;
        fetch_addr = AddrW'($urandom_range(0, Depth - 1));
        tick();
        if (ld_done === 1'b1) pulses++;
        if (fetch_during) begin
          checks++;
          if (instr_valid !== 1'b0) $display("FAIL fetch_in_load: got %b want 0", instr_valid);
          else passed++;
        end
      end
      ld_valid = 1'b1;
      ld_byte  = bytes[i];
      fetch_en = fetch_during;
      tick();
      if (ld_done === 1'b1) pulses++;
      if (fetch_during) begin
        checks++;
        if (instr_valid !== 1'b0) $display("FAIL fetch_in_load: got %b want 0", instr_valid);
        else passed++;
      end
    end
    ld_valid = 1'b0;
    fetch_en = 1'b0;
    checks++;
    if (ld_done !== 1'b1 || pulses != 1 || busy !== 1'b1 || ld_ready !== 1'b0)
      $display("FAIL load_done: got done=%b pulses=%0d busy=%b ready=%b want 1/1/1/0", ld_done,
               pulses, busy, ld_ready);
    else passed++;
    tick();
    checks++;
    if (ld_done !== 1'b0 || busy !== 1'b0)
      $display("FAIL load_idle: got done=%b busy=%b want 0/0", ld_done, busy);
    else passed++;
    for (int k = 0; k < count; k++) begin
      w = '0;
      for (int b = 0; b < Bpw; b++) w = (w << 8) | DataW'(bytes[k * Bpw + b]);
      model_mem[(base + k) % Depth]   = w;
      model_known[(base + k) % Depth] = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_start = 1'b0; ld_base = '0; ld_count = '0; ld_valid = 1'b0; ld_byte = '0;
    fetch_en = 1'b0; fetch_addr = '0;
    tick();
    checks++;
    if (instr !== '0 || instr_valid !== 1'b0) $display("FAIL reset_instr: got %h/%b want 0/0", instr, instr_valid);
    else passed++;
    checks++;
    if (ld_ready !== 1'b0 || busy !== 1'b0 || ld_done !== 1'b0)
      $display("FAIL reset_ctrl: got ready=%b busy=%b done=%b want 0/0/0", ld_ready, busy, ld_done);
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed_load();
    logic [7:0] q [$];
    q = {8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    do_load(0, 2, q, 1'b0, -1);
    do_fetch(0);
    do_fetch(1);
    checks++;
    if (instr !== 32'h9ABCDEF0) $display("FAIL directed_word1: got %h want 9abcdef0", instr);
    else passed++;
  endtask

  task automatic test_fetch_during_load();
    logic [7:0] q [$];
    rand_bytes(Bpw, q);
    do_load(20, 1, q, 1'b1, -1);
    do_fetch(20);
  endtask

  task automatic test_wrap();
    logic [7:0] q [$];
    rand_bytes(2 * Bpw, q);
    do_load(63, 2, q, 1'b0, -1);
    do_fetch(63);
    do_fetch(0);
  endtask

  task automatic test_zero_count();
    logic [7:0] q [$];
    q = {};
    do_load(1, 0, q, 1'b0, -1);
    do_fetch(0);
    do_fetch(1);
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] q [$];
    logic [DataW-1:0] w;
    rand_bytes(2 * Bpw, q);
    do_load(10, 2, q, 1'b0, -1);
    do_fetch(11);
    rand_bytes(2 * Bpw, q);
    ld_start = 1'b1; ld_base = AddrW'(10); ld_count = (AddrW + 1)'(2);
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1'b1;
      ld_byte  = q[i];
      tick();
    end
    ld_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (instr !== '0 || instr_valid !== 1'b0 || ld_ready !== 1'b0 || busy !== 1'b0 || ld_done !== 1'b0)
      $display("FAIL abort_outputs: got instr=%h valid=%b ready=%b busy=%b done=%b want all 0",
               instr, instr_valid, ld_ready, busy, ld_done);
    else passed++;
    w = '0;
    for (int b = 0; b < Bpw; b++) w = (w << 8) | DataW'(q[b]);
    model_mem[10] = w;
    tick();
    rst = 1'b0;
    repeat (3) begin
      tick();
      checks++;
      if (ld_done !== 1'b0 || busy !== 1'b0)
        $display("FAIL abort_no_done: got done=%b busy=%b want 0/0", ld_done, busy);
      else passed++;
    end
    do_fetch(10);
    do_fetch(11);
  endtask

  task automatic test_same_cycle();
    logic [7:0] q [$];
    rand_bytes(Bpw, q);
    do_load(30, 1, q, 1'b0, -1);
    rand_bytes(Bpw, q);
    do_load(30, 1, q, 1'b0, 30);
    do_fetch(30);
  endtask

  task automatic test_random();
    logic [7:0] q [$];
    int base, count, a;
    for (int it = 0; it < 12; it++) begin
      base  = $urandom_range(0, Depth - 1);
      count = $urandom_range(1, 4);
      rand_bytes(count * Bpw, q);
      do_load(base, count, q, ($urandom_range(0, 1) == 1), -1);
      do_fetch((base + $urandom_range(0, count - 1)) % Depth);
      a = $urandom_range(0, Depth - 1);
      while (!model_known[a]) a = (a + 1) % Depth;
      do_fetch(a);
    end
  endtask

`ifdef IMEM_PARITY_EN
  task automatic test_parity();
    logic [7:0] q [$];
    rand_bytes(Bpw, q);
    do_load(3, 1, q, 1'b0, -1);
    do_fetch(3);
    dut.mem[3][5] = ~dut.mem[3][5];
    fetch_en   = 1'b1;
    fetch_addr = AddrW'(3);
    tick();
    fetch_en = 1'b0;
    checks++;
    if (parity_err !== 1'b1 || instr_valid !== 1'b1)
      $display("FAIL parity_flip: got err=%b valid=%b want 1/1", parity_err, instr_valid);
    else passed++;
    tick();
  endtask
`endif

  initial begin
    for (int i = 0; i < Depth; i++) begin
      model_mem[i]   = '0;
      model_known[i] = 1'b0;
    end
    model_instr = '0;
    test_reset();
    test_directed_load();
    test_fetch_during_load();
    test_wrap();
    test_zero_count();
    test_reset_mid_load();
    test_same_cycle();
    test_random();
`ifdef IMEM_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
